// File: rtl/stage_unloader_8_if.sv
// stage_unloader_8_if: snapshot load and word stream handshake; out_parity only with STAGE_UNLOADER_PARITY_EN
interface stage_unloader_8_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
);
    logic                   load_valid;
    logic                   load_ready;
    logic [WIDTH*DEPTH-1:0] load_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_last;
    logic                   busy;
    logic [CNT_W-1:0]       count_remaining;
`ifdef STAGE_UNLOADER_PARITY_EN
    logic                   out_parity;
`endif
    modport master (
        input  load_valid, load_data, out_ready,
`ifdef STAGE_UNLOADER_PARITY_EN
        output out_parity,
`endif
        output load_ready, out_valid, out_data, out_last, busy, count_remaining
    );
    modport slave (
        output load_valid, load_data, out_ready,
`ifdef STAGE_UNLOADER_PARITY_EN
        input  out_parity,
`endif
        input  load_ready, out_valid, out_data, out_last, busy, count_remaining
    );
endinterface

// File: rtl/stage_unloader_8.sv
// stage_unloader_8: parallel snapshot load drained oldest-first as a word stream; STAGE_UNLOADER_PARITY_EN adds out_parity
module stage_unloader_8 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input logic               clk,
    input logic               reset_n,
    stage_unloader_8_if.master bus
);
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t                       state, state_d;
    logic [DEPTH-1:0][WIDTH-1:0]  sreg;
    logic [CNT_W-1:0]             cnt;
    logic                         beat, last, load;
    assign beat = bus.out_valid & bus.out_ready;
    assign last = bus.out_last & bus.out_ready;
    assign load = bus.load_valid & bus.load_ready;
    assign bus.load_ready      = (state == IDLE) | last;
    assign bus.out_valid       = state == DRAIN;
    assign bus.busy            = state == DRAIN;
    assign bus.out_data        = sreg[DEPTH-1];
    assign bus.out_last        = cnt == CNT_W'(1);
    assign bus.count_remaining = cnt;
`ifdef STAGE_UNLOADER_PARITY_EN
    assign bus.out_parity      = ^sreg[DEPTH-1];
`endif
    always_comb begin
        state_d = load ? DRAIN : last ? IDLE : state;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end
    // zero fill means a fully drained buffer already reads as 0 in IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= bus.load_data;
            cnt  <= CNT_W'(DEPTH);
        end else if (beat) begin
            sreg <= {sreg[DEPTH-2:0], WIDTH'(0)};
            cnt  <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_stage_unloader_8.sv
// tb_stage_unloader_8: queue-model scoreboard plus directed and random stimulus for stage_unloader_8
module tb_stage_unloader_8;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic clk = 0;
    logic reset_n = 0;
    logic run = 0;
    int   total = 0;
    int   bad = 0;
    logic [WIDTH-1:0] q[$];

    stage_unloader_8_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
    stage_unloader_8 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_snap(input logic [WIDTH-1:0] base);
        for (int k = 0; k < DEPTH; k++) bus.load_data[k*WIDTH +: WIDTH] = base + WIDTH'(k);
    endtask

    // model: the words still owed to the consumer, oldest at the front
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) q.delete();
        else begin
            automatic bit lr = (q.size() == 0) || (q.size() == 1 && bus.out_ready);
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (bus.load_valid && lr)
                for (int k = DEPTH - 1; k >= 0; k--) q.push_back(bus.load_data[k*WIDTH +: WIDTH]);
        end
    end

    always @(negedge clk) if (run) begin
        automatic int n = q.size();
        chk("out_valid", 32'(bus.out_valid), 32'(n > 0));
        chk("busy", 32'(bus.busy), 32'(n > 0));
        chk("out_data", 32'(bus.out_data), n > 0 ? 32'(q[0]) : 32'd0);
        chk("out_last", 32'(bus.out_last), 32'(n == 1));
        chk("count_remaining", 32'(bus.count_remaining), 32'(n));
        chk("load_ready", 32'(bus.load_ready), 32'(n == 0 || (n == 1 && bus.out_ready)));
`ifdef STAGE_UNLOADER_PARITY_EN
        chk("out_parity", 32'(bus.out_parity), n > 0 ? 32'(^q[0]) : 32'd0);
`endif
    end

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 64 && bus.busy; i++) step();
        chk({name, "_timeout"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.load_valid = 0;
        bus.out_ready = 0;
        bus.load_data = '0;
        step();
        run = 1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.count_remaining), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        reset_n = 1;
        step();
        chk("rst_load_ready", 32'(bus.load_ready), 32'd1);

        // straight drain
        set_snap(16'h1000);
        bus.load_valid = 1;
        step();
        bus.load_valid = 0;
        bus.out_ready = 1;
        chk("first_word", 32'(bus.out_data), 32'h1007);
        chk("first_count", 32'(bus.count_remaining), 32'd8);
        chk("first_last", 32'(bus.out_last), 32'd0);
        for (int i = 0; i < 7; i++) step();
        chk("final_word", 32'(bus.out_data), 32'h1000);
        chk("final_last", 32'(bus.out_last), 32'd1);
        chk("final_load_ready", 32'(bus.load_ready), 32'd1);
        step();
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_data", 32'(bus.out_data), 32'd0);

        // stalls with out_ready pattern 1,0,0,1
        bus.out_ready = 0;
        bus.load_valid = 1;
        step();
        bus.load_valid = 0;
        for (int i = 0; i < 64 && bus.busy; i++) begin
            bus.out_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        chk("stall_done", 32'(bus.busy), 32'd0);

        // back-to-back snapshots
        bus.out_ready = 1;
        bus.load_valid = 1;
        step();
        set_snap(16'h2000);
        for (int i = 0; i < 7; i++) step();
        chk("b2b_lr_last", 32'(bus.load_ready), 32'd1);
        step();
        bus.load_valid = 0;
        chk("b2b_second_word", 32'(bus.out_data), 32'h2007);
        chk("b2b_second_count", 32'(bus.count_remaining), 32'd8);
        wait_idle("b2b");

        // load offered mid-drain is ignored
        set_snap(16'h3000);
        bus.load_valid = 1;
        step();
        bus.load_valid = 0;
        step(); step(); step();
        set_snap(16'h4000);
        bus.load_valid = 1;
        chk("mid_load_ready", 32'(bus.load_ready), 32'd0);
        step();
        bus.load_valid = 0;
        chk("mid_word", 32'(bus.out_data), 32'h3003);
        wait_idle("mid");

        // asynchronous reset mid-drain
        bus.load_valid = 1;
        step();
        bus.load_valid = 0;
        for (int i = 0; i < 4; i++) step();
        #2 reset_n = 0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_count", 32'(bus.count_remaining), 32'd0);
        step();
        reset_n = 1;
        set_snap(16'h5000);
        bus.load_valid = 1;
        step();
        bus.load_valid = 0;
        chk("arst_reload", 32'(bus.out_data), 32'h5007);
        wait_idle("arst");

`ifdef STAGE_UNLOADER_PARITY_EN
        bus.load_data = '0;
        bus.load_data[(DEPTH-1)*WIDTH +: WIDTH] = 16'h0007;
        bus.load_data[(DEPTH-2)*WIDTH +: WIDTH] = 16'h0003;
        bus.load_valid = 1;
        step();
        bus.load_valid = 0;
        chk("parity_7", 32'(bus.out_parity), 32'd1);
        step();
        chk("parity_3", 32'(bus.out_parity), 32'd0);
        wait_idle("parity");
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < DEPTH; k++) bus.load_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
            step();
        end
        bus.load_valid = 0;
        bus.out_ready = 1;
        wait_idle("rand");
        step();
        run = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stage_unloader_8.md
Name: stage_unloader_8

Overview:
- Reader-side counterpart to the team's 8-stage 16-bit shift pipeline.
- Captures a full 8-word snapshot (stage A..H) in one parallel load, then drains it as a serial word stream, oldest word (H) first.
- Uses a valid/ready handshake on the output.
- Sits between the stage pipeline and downstream consumers that take one word per beat.

Parameters:
- WIDTH, 16, bits per word.
- DEPTH, 8, words per snapshot; must be >= 2.
- CNT_W, 4, width of the remaining-count output; must hold the value DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  snapshot offered on load_data.
- load_ready  output  1  block can accept a snapshot this cycle.
- load_data  input  WIDTH*DEPTH  snapshot; slice k = bits [k*WIDTH +: WIDTH]; slice 0 = stage A (newest), slice DEPTH-1 = stage H (oldest).
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_data  output  WIDTH  current word.
- out_last  output  1  current word is the final word of the snapshot.
- busy  output  1  snapshot in progress (state DRAIN).
- count_remaining  output  CNT_W  words not yet accepted by the consumer.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, buffer all zero, count_remaining=0, out_valid=0, out_last=0, busy=0, out_data=0. load_ready=1 once reset is released.
- States: IDLE and DRAIN.
- IDLE:
  - load_ready=1, out_valid=0.
  - load_valid=1 at an edge: capture load_data into buffer, count_remaining<=DEPTH, go to DRAIN.
- DRAIN:
  - out_valid=1, busy=1.
  - out_data = buffer slot DEPTH-1, taken straight from a register (no combinational path from inputs).
  - out_last = (count_remaining==1).
- Beat: out_valid & out_ready at an edge.
  - Buffer shifts toward the top: slot k <= slot k-1; slot 0 <= 0.
  - count_remaining decrements.
- Last beat (out_last & out_ready):
  - If load_valid is also high, the new snapshot loads in the same edge, count_remaining<=DEPTH, and the block stays in DRAIN. Gives back-to-back snapshots with no bubble.
  - Otherwise go to IDLE, count_remaining<=0, out_data<=0.
- load_ready = (state==IDLE) | (out_last & out_ready). This is the only combinational input-to-output path.
- Stall: out_valid high and out_ready low holds out_data, out_last and count_remaining stable indefinitely.
- load_valid in DRAIN without a last beat is ignored. No capture; the upstream holds the snapshot.
- Latency: snapshot accepted at edge N puts word H on out_data with out_valid=1 after edge N. With out_ready held high, one word per cycle; DEPTH beats per snapshot.
- Word order on the stream: H, G, F, E, D, C, B, A.
- Reset asserted mid-drain discards the remaining words immediately. No partial out_last.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: STAGE_UNLOADER_PARITY_EN.
- When defined:
  - Adds output out_parity (1 bit) = even parity (XOR) of out_data.
  - out_parity follows the same registered timing as out_data; 0 in IDLE and after reset.
- When undefined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then load slices 0x000A..0x000H mapped as slice k = 0x1000+k, out_ready=1 -> out_data 0x1007,0x1006,...,0x1000 on 8 consecutive cycles. out_last only on 0x1000. count_remaining 8..1, then IDLE with busy=0.
- Same load, out_ready toggled 1,0,0,1... -> each word held stable while out_ready=0. No word lost or repeated; count_remaining is unchanged during stalls.
- Two snapshots (0x1000+k, then 0x2000+k) with load_valid held high and out_ready=1 -> 16 contiguous beats 0x1007..0x1000 then 0x2007..0x2000. load_ready pulses only on the 0x1000 beat; no idle cycle.
- Second load_valid in DRAIN at beat 3 with out_ready=1 -> not captured (load_ready=0). First snapshot completes intact.
- Drop reset_n during beat 4 -> out_valid, busy and count_remaining are 0 immediately (asynchronous). After release, a new load drains all 8 words correctly.
- With STAGE_UNLOADER_PARITY_EN, word 0x0007 -> out_parity=1; word 0x0003 -> out_parity=0.
